result_drain: RTL

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/result_drain.sv
// result_drain: serialises a 4x4 result matrix into 16 row-major valid/ready beats.
// Optional feature: define RESULT_DRAIN_DOUBLEBUF_EN to add one pending capture
// buffer so a new result can be accepted while the current one is draining.
//
// Handshake: a beat transfers on a cycle where o_valid && i_ready. o_valid is
// a pure function of registered state (never of i_ready). While o_valid is
// high and i_ready is low, o_data/o_row/o_col/o_last hold their values.
module result_drain #(
    parameter int DATA_W = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [3:0][3:0][DATA_W-1:0]  i_c,
    input  logic                         i_validResult,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_W-1:0]            o_data,
    output logic [1:0]                   o_row,
    output logic [1:0]                   o_col,
    output logic                         o_last,
    output logic                         o_busy,
    output logic                         o_overrun,
    output logic [7:0]                   o_resultCount
);

    if (DATA_W != 32) begin : g_bad_width
        $error("result_drain: DATA_W must be 32");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0][3:0][DATA_W-1:0]   act_q;
    logic [3:0]                    idx_q;
    logic [7:0]                    count_q;
    logic                          overrun_q;

    logic                          xfer;
    logic                          last_xfer;
    logic                          load_new;
    logic                          drop;

`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    logic [3:0][3:0][DATA_W-1:0]   pend_q;
    logic                          pend_full_q;
    logic                          load_from_pend;
    logic                          pend_cap;
    logic                          pend_clr;
`endif

    assign o_valid   = (state_q == DRAIN);
    assign xfer      = o_valid & i_ready;
    assign last_xfer = xfer & (idx_q == 4'd15);

    // Next-state and buffer-control decode.
    always_comb begin
        state_d  = state_q;
        load_new = 1'b0;
        drop     = 1'b0;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
        load_from_pend = 1'b0;
        pend_cap       = 1'b0;
        pend_clr       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_validResult) begin
                    load_new = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
                if (last_xfer) begin
                    if (pend_full_q) begin
                        // Pending matrix moves up; a coincident pulse refills pending.
                        load_from_pend = 1'b1;
                        if (i_validResult) pend_cap = 1'b1;
                        else               pend_clr = 1'b1;
                    end else if (i_validResult) begin
                        load_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_validResult) begin
                    if (!pend_full_q) pend_cap = 1'b1;
                    else              drop     = 1'b1;
                end
`else
                if (last_xfer) begin
                    if (i_validResult) load_new = 1'b1;
                    else               state_d  = IDLE;
                end else if (i_validResult) begin
                    drop = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, beat index, active buffer, counters and sticky overrun.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            act_q     <= '0;
            count_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // idx wraps 15 -> 0 on the last transfer, so a new matrix starts at [0][0].
            if (xfer) idx_q <= idx_q + 4'd1;
            if (load_new) act_q <= i_c;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
            else if (load_from_pend) act_q <= pend_q;
`endif
            if (last_xfer) count_q <= count_q + 8'd1;
            if (drop) overrun_q <= 1'b1;
        end
    end

`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    // Pending buffer: captures a result that arrives mid-drain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (pend_cap) begin
                pend_q      <= i_c;
                pend_full_q <= 1'b1;
            end else if (pend_clr) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    assign o_busy = pend_full_q;
`else
    assign o_busy = o_valid;
`endif

    assign o_data        = o_valid ? act_q[idx_q[3:2]][idx_q[1:0]] : '0;
    assign o_row         = idx_q[3:2];
    assign o_col         = idx_q[1:0];
    assign o_last        = o_valid & (idx_q == 4'd15);
    assign o_overrun     = overrun_q;
    assign o_resultCount = count_q;

endmodule
